div_seq: RTL and testbench
==========================

# div_seq

Parametrised, multi-cycle signed/unsigned integer divider for the datapath's DIV instruction. It replaces the single-cycle combinational array with a restoring iterative divider that retires RADIX_BITS quotient bits per clock. The divider accepts one operation at a time through a start/ready/done handshake and returns registered quotient and remainder into the HI/LO path. Sign and divide-by-zero semantics are unchanged: truncating division, quotient 0 and remainder = dividend on a zero divisor.

## Interface
- WIDTH, 32, operand/result width; even, ≥ 4.
- RADIX_BITS, 1, quotient bits resolved per ITER cycle; 1 or 2; WIDTH % RADIX_BITS == 0.
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge when start && ready.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
- dividend  in  WIDTH  sampled at acceptance.
- divisor  in  WIDTH  sampled at acceptance.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  registered; held until the next done.
- remainder  out  WIDTH  registered; held until the next done.
- div_zero  out  1  divisor was 0; valid with done, held.
- overflow  out  1  signed MIN / -1; valid with done, held.
- abort  in  1  only with DIV_SEQ_ABORT_EN.

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: ready=1. On start, latch the operands and is_signed, then go to PREP.
- PREP:
  - Signed mode: take the magnitudes of both operands; sign_q = dividend MSB ^ divisor MSB; sign_r = dividend MSB. Unsigned mode: both sign flags are 0.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter.
  - Divisor == 0: skip ITER and go to FIX with div_zero set.
- ITER: each cycle, for each of RADIX_BITS sub-steps, do rem = {rem, next dividend bit}. If rem ≥ |divisor|, subtract it and set the quotient bit. Runs for exactly WIDTH/RADIX_BITS cycles.
- FIX:
  - Negate the quotient if sign_q; negate the remainder if sign_r. Load the output registers, pulse done, return to IDLE.
  - div_zero: quotient = 0, remainder = original dividend.
  - overflow: set when is_signed, dividend = 1 followed by WIDTH-1 zeros, and divisor = all ones. Quotient = dividend (wrapped), remainder = 0.
- The remainder sign always follows the dividend; the quotient truncates toward zero.
- start while not ready is ignored; no queueing.
- start in the done cycle is accepted, because ready=1 in that cycle. This gives back-to-back operation.

## Timing
- Reset values: state = IDLE, ready=1, done=0, quotient=0, remainder=0, div_zero=0, overflow=0.
- Reset asserted mid-operation returns the block to IDLE immediately and discards the operation; no done pulse follows.
- Latency: done is high in the cycle after WIDTH/RADIX_BITS + 2 rising edges following the acceptance edge. Defaults: 34 edges for RADIX_BITS=1, 18 for RADIX_BITS=2.
- Divide-by-zero latency: 2 edges (PREP, FIX).
- ready=0 from the cycle after acceptance through FIX; it returns to 1 together with done.
- Operand inputs may change freely after acceptance.

## Configuration
- DIV_SEQ_ABORT_EN defined:
  - Adds the abort input.
  - abort high on any edge in PREP or ITER returns the block to IDLE on that edge.
  - No done pulse; outputs keep their previous values.
  - abort in IDLE or FIX has no effect.
- Undefined: no abort port; every accepted operation completes.

## Test plan
- Signed, WIDTH=32: -7 / 2 → quotient -3, remainder -1. 7 / -2 → quotient -3, remainder 1. done exactly 34 edges after acceptance.
- Unsigned: 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF. The same operands with is_signed=1 → quotient 0, remainder -1.
- Zero divisor: 100 / 0 → quotient 0, remainder 100, div_zero=1, done 2 edges after acceptance.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, overflow=1.
- Back-to-back: new start in the done cycle is accepted; a second start mid-ITER is ignored. RADIX_BITS=2 run of 1000 / 7 → quotient 142, remainder 6 in 18 edges.
- clr_n pulsed at ITER cycle 10 → all outputs return to reset values, no done. With DIV_SEQ_ABORT_EN, abort at ITER cycle 5 → IDLE, previous results held.

Source files
------------

// File: rtl/div_seq.sv
// Iterative restoring signed/unsigned divider, RADIX_BITS quotient bits per ITER cycle.
// Latency WIDTH/RADIX_BITS+2 edges after acceptance (2 on zero divisor); optional abort via DIV_SEQ_ABORT_EN.
module div_seq #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sgn;
  logic [WIDTH-1:0] wrk, wrk_s;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem, rem_s;
  logic             sign_q, sign_r;
  logic [CW-1:0]    cnt;

  logic             abort_hit;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic             dz, ovf;

`ifdef DIV_SEQ_ABORT_EN
  assign abort_hit = abort && (state == PREP || state == ITER);
`else
  assign abort_hit = 1'b0;
`endif

  assign ready = (state == IDLE);
  assign a_mag = (op_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag = (op_sgn && op_b[WIDTH-1]) ? -op_b : op_b;
  assign dz    = (op_b == '0);
  assign ovf   = op_sgn && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
  assign q_fix = sign_q ? -wrk : wrk;
  assign r_fix = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        if (abort_hit) state_d = IDLE;
        else if (dz)   state_d = FIX;
        else           state_d = ITER;
      end
      ITER: begin
        if (abort_hit)                       state_d = IDLE;
        else if (cnt == CW'(STEPS - 1))      state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The working register shifts dividend bits out the top and quotient bits in at the bottom.
  always_comb begin
    rem_s = rem;
    wrk_s = wrk;
    for (int i = 0; i < RADIX_BITS; i++) begin
      rem_s = {rem_s[WIDTH-1:0], wrk_s[WIDTH-1]};
      wrk_s = {wrk_s[WIDTH-2:0], 1'b0};
      if (rem_s >= {1'b0, dvs_mag}) begin
        rem_s    = rem_s - {1'b0, dvs_mag};
        wrk_s[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_sgn    <= 1'b0;
      wrk       <= '0;
      dvs_mag   <= '0;
      rem       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= dividend;
            op_b   <= divisor;
            op_sgn <= is_signed;
          end
        end
        PREP: begin
          wrk     <= a_mag;
          dvs_mag <= b_mag;
          rem     <= '0;
          cnt     <= '0;
          sign_q  <= op_sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          sign_r  <= op_sgn && op_a[WIDTH-1];
        end
        ITER: begin
          wrk <= wrk_s;
          rem <= rem_s;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done     <= 1'b1;
          div_zero <= dz;
          overflow <= ovf;
          // MIN / -1 already yields MIN with zero remainder from the magnitude path.
          if (dz) begin
            quotient  <= '0;
            remainder <= op_a;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: signs, zero divisor, overflow, back-to-back, latency, reset (and abort when enabled).
module tb_div_seq;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        abort = 1'b0;
  logic        ready0, done0, dz0, ov0, ready1, done1, dz1, ov1;
  logic [31:0] quo0, rem0, quo1, rem1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32), .RADIX_BITS(1)) dut0 (
    .clk(clk), .clr_n(clr_n), .start(start0), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
`ifdef DIV_SEQ_ABORT_EN
    .abort(abort),
`endif
    .ready(ready0), .done(done0), .quotient(quo0), .remainder(rem0),
    .div_zero(dz0), .overflow(ov0)
  );

  div_seq #(.WIDTH(32), .RADIX_BITS(2)) dut1 (
    .clk(clk), .clr_n(clr_n), .start(start1), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
`ifdef DIV_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .ready(ready1), .done(done1), .quotient(quo1), .remainder(rem1),
    .div_zero(dz1), .overflow(ov1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents one request for a single edge; caller is always #1 past an edge.
  task automatic op_start(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic sg);
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int k);
    bit seen;
    seen = 0;
    k = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (sel ? done1 : done0) seen = 1;
    end
    if (!seen) k = -1;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done0) cnt++;
    end
  endtask

  initial begin
    int k;
    int nd;

    #12;
    check("rst_ready", ready0, 1);
    check("rst_done", done0, 0);
    check("rst_quo", quo0, 0);
    check("rst_rem", rem0, 0);
    check("rst_flags", {dz0, ov0}, 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // -7 / 2
    op_start(0, 32'hFFFF_FFF9, 32'd2, 1);
    check("busy_ready", ready0, 0);
    wait_done(0, k);
    check("lat_r1", k, 34);
    check("neg_dvd_q", quo0, 32'hFFFF_FFFD);
    check("neg_dvd_r", rem0, 32'hFFFF_FFFF);
    check("neg_dvd_flags", {dz0, ov0}, 0);
    check("done_ready", ready0, 1);
    @(posedge clk);
    #1;
    check("done_pulse", done0, 0);

    // 7 / -2
    op_start(0, 32'd7, 32'hFFFF_FFFE, 1);
    wait_done(0, k);
    check("neg_dvs_q", quo0, 32'hFFFF_FFFD);
    check("neg_dvs_r", rem0, 32'd1);

    op_start(0, 32'hFFFF_FFFF, 32'h10, 0);
    wait_done(0, k);
    check("uns_q", quo0, 32'h0FFF_FFFF);
    check("uns_r", rem0, 32'hF);

    op_start(0, 32'hFFFF_FFFF, 32'h10, 1);
    wait_done(0, k);
    check("sgn_q", quo0, 32'h0);
    check("sgn_r", rem0, 32'hFFFF_FFFF);

    op_start(0, 32'd100, 32'd0, 0);
    wait_done(0, k);
    check("dz_lat", k, 2);
    check("dz_q", quo0, 0);
    check("dz_r", rem0, 32'd100);
    check("dz_flag", dz0, 1);

    op_start(0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done(0, k);
    check("ovf_q", quo0, 32'h8000_0000);
    check("ovf_r", rem0, 0);
    check("ovf_flag", {dz0, ov0}, 2'b01);

    // Back-to-back: start held through the op with new operands (ignored mid-op), accepted in done cycle.
    dividend = 32'd50; divisor = 32'd6; is_signed = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1;
    dividend = 32'd1000; divisor = 32'd7;
    wait_done(0, k);
    check("b2b_lat_a", k, 34);
    check("b2b_q_a", quo0, 32'd8);
    check("b2b_r_a", rem0, 32'd2);
    check("b2b_ready", ready0, 1);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("b2b_accept", ready0, 0);
    wait_done(0, k);
    check("b2b_lat_b", k, 34);
    check("b2b_q_b", quo0, 32'd142);
    check("b2b_r_b", rem0, 32'd6);

    op_start(1, 32'd1000, 32'd7, 0);
    wait_done(1, k);
    check("r2_lat", k, 18);
    check("r2_q", quo1, 32'd142);
    check("r2_r", rem1, 32'd6);

`ifdef DIV_SEQ_ABORT_EN
    op_start(0, 32'd20, 32'd3, 0);
    wait_done(0, k);
    op_start(0, 32'd100, 32'd9, 0);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_ready", ready0, 1);
    count_done(45, nd);
    check("abort_nodone", nd, 0);
    check("abort_q_held", quo0, 32'd6);
    check("abort_r_held", rem0, 32'd2);
`endif

    // Reset mid-ITER after outputs hold a non-zero result.
    op_start(0, 32'd7, 32'hFFFF_FFFE, 1);
    repeat (11) @(posedge clk);
    #1;
    clr_n = 1'b0;
    #1;
    check("mid_rst_ready", ready0, 1);
    check("mid_rst_q", quo0, 0);
    check("mid_rst_r", rem0, 0);
    check("mid_rst_flags", {done0, dz0, ov0}, 0);
    @(negedge clk);
    clr_n = 1'b1;
    count_done(45, nd);
    check("mid_rst_nodone", nd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
